gcd_ctrl: RTL and testbench

//  Control FSM for the subtractive GCD datapath (gcd_data); drives its ldA/ldB/sel/out/strt lines.
//  - Host side: go/ack handshake with busy, done and err status.
//  - Datapath side: consumes comparator/zero flags derived from the datapath's registered A/B.
//  - Bounds runtime with an iteration counter; rejects zero operands.

---
 rtl/gcd_pkg.sv | 23 ++
 rtl/gcd_iter_counter.sv | 26 ++
 rtl/gcd_ctrl.sv | 85 ++++++++
 tb/tb_gcd_ctrl.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/gcd_pkg.sv
// rtl/gcd_pkg.sv - shared state encoding, defaults and flag helper for the GCD controller
package gcd_pkg;

    localparam int MAX_ITER_DEF = 15;
    localparam int CNT_W_DEF    = 4;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_LOAD = 3'd1,
        ST_CALC = 3'd2,
        ST_DONE = 3'd3,
        ST_ERR  = 3'd4
    } state_t;

    localparam logic SEL_A_MINUS_B = 1'b1;
    localparam logic SEL_B_MINUS_A = 1'b0;

    // A healthy comparator raises exactly one of gt/lt/eq.
    function automatic logic flags_onehot(input logic gt, input logic lt, input logic eq);
        return (gt ^ lt ^ eq) & ~(gt & lt & eq);
    endfunction

endpackage

// File: rtl/gcd_iter_counter.sv
// rtl/gcd_iter_counter.sv - subtract-cycle counter with terminal-count flag
module gcd_iter_counter #(
    parameter int CNT_W    = 4,
    parameter int MAX_ITER = 15
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             inc,
    output logic [CNT_W-1:0] cnt,
    output logic             at_max
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign at_max = (cnt == CNT_W'(MAX_ITER));

endmodule

// File: rtl/gcd_ctrl.sv
// rtl/gcd_ctrl.sv - control FSM for the subtractive GCD datapath
module gcd_ctrl
    import gcd_pkg::*;
#(
    parameter int MAX_ITER = MAX_ITER_DEF,
    parameter int CNT_W    = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             go,
    input  logic             ack,
    input  logic             a_gt_b,
    input  logic             a_lt_b,
    input  logic             a_eq_b,
    input  logic             a_zero,
    input  logic             b_zero,
    output logic             ldA,
    output logic             ldB,
    output logic             sel,
    output logic             out,
    output logic             strt,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [CNT_W-1:0] iter_cnt
);

    state_t state;
    logic   zero_hit;
    logic   flags_ok;
    logic   calc_sub;
    logic   cnt_clr;
    logic   at_max;

    // Outputs in CALC follow the live comparator flags, so they are decoded, not registered.
    always_comb begin
        zero_hit = a_zero | b_zero;
        flags_ok = flags_onehot(a_gt_b, a_lt_b, a_eq_b);
        calc_sub = (state == ST_CALC) & ~zero_hit & ~a_eq_b & flags_ok & ~at_max;
        cnt_clr  = (state == ST_IDLE) & go;
    end

    gcd_iter_counter #(
        .CNT_W    (CNT_W),
        .MAX_ITER (MAX_ITER)
    ) u_iter_counter (
        .clk    (clk),
        .rst    (rst),
        .clr    (cnt_clr),
        .inc    (calc_sub),
        .cnt    (iter_cnt),
        .at_max (at_max)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: if (go) state <= ST_LOAD;
                ST_LOAD: state <= ST_CALC;
                ST_CALC: begin
                    if (zero_hit)                state <= ST_ERR;
                    else if (a_eq_b)             state <= ST_DONE;
                    else if (!flags_ok || at_max) state <= ST_ERR;
                end
                ST_DONE: if (ack) state <= ST_IDLE;
                ST_ERR:  if (ack) state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

    always_comb begin
        ldA  = (state == ST_LOAD);
        ldB  = (state == ST_LOAD);
        busy = (state == ST_LOAD) | (state == ST_CALC);
        done = (state == ST_DONE);
        err  = (state == ST_ERR);
        out  = (state == ST_DONE);
        strt = (state == ST_DONE) | calc_sub;
        sel  = (calc_sub & a_gt_b) ? SEL_A_MINUS_B : SEL_B_MINUS_A;
    end

endmodule

// File: tb/tb_gcd_ctrl.sv
// tb/tb_gcd_ctrl.sv - randomized bench for gcd_ctrl driving a behavioural gcd datapath
module tb_gcd_ctrl;

    typedef struct {
        logic       ld;
        logic       sel;
        logic       out;
        logic       strt;
        logic       busy;
        logic       done;
        logic       err;
        logic [3:0] cnt;
        logic       chk_gcd;
        logic [3:0] gcd;
    } rec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int   errors = 0;
    int   checks = 0;
    rec_t exp_q[$];
    bit   model_on = 1'b0;
    int   model_cnt = 0;
    int   last_gcd = -1;

    // main DUT and its datapath
    logic       go = 1'b0, ack = 1'b0, corrupt = 1'b0;
    logic [3:0] da = '0, db = '0, a_reg, b_reg;
    logic       a_gt_b, a_lt_b, a_eq_b, a_zero, b_zero;
    logic       ldA, ldB, sel, out, strt, busy, done, err;
    logic [3:0] iter_cnt;

    assign a_gt_b = (a_reg > b_reg) | (corrupt & (a_reg != b_reg));
    assign a_lt_b = (a_reg < b_reg) | (corrupt & (a_reg != b_reg));
    assign a_eq_b = (a_reg == b_reg);
    assign a_zero = (a_reg == 4'd0);
    assign b_zero = (b_reg == 4'd0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_reg <= '0;
            b_reg <= '0;
        end else begin
            if (ldA) a_reg <= da;
            if (ldB) b_reg <= db;
            if (strt && !out) begin
                if (sel) a_reg <= a_reg - b_reg;
                else     b_reg <= b_reg - a_reg;
            end
        end
    end

    gcd_ctrl u_dut (
        .clk(clk), .rst(rst), .go(go), .ack(ack),
        .a_gt_b(a_gt_b), .a_lt_b(a_lt_b), .a_eq_b(a_eq_b), .a_zero(a_zero), .b_zero(b_zero),
        .ldA(ldA), .ldB(ldB), .sel(sel), .out(out), .strt(strt),
        .busy(busy), .done(done), .err(err), .iter_cnt(iter_cnt)
    );

    // short-timeout DUT with its own datapath
    logic       go3 = 1'b0, ack3 = 1'b0;
    logic [3:0] a3, b3;
    logic       ldA3, ldB3, sel3, out3, strt3, busy3, done3, err3;
    logic [3:0] iter3;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a3 <= '0;
            b3 <= '0;
        end else begin
            if (ldA3) a3 <= 4'd15;
            if (ldB3) b3 <= 4'd1;
            if (strt3 && !out3) begin
                if (sel3) a3 <= a3 - b3;
                else      b3 <= b3 - a3;
            end
        end
    end

    gcd_ctrl #(.MAX_ITER(3), .CNT_W(4)) u_dut3 (
        .clk(clk), .rst(rst), .go(go3), .ack(ack3),
        .a_gt_b(a3 > b3), .a_lt_b(a3 < b3), .a_eq_b(a3 == b3), .a_zero(a3 == 4'd0), .b_zero(b3 == 4'd0),
        .ldA(ldA3), .ldB(ldB3), .sel(sel3), .out(out3), .strt(strt3),
        .busy(busy3), .done(done3), .err(err3), .iter_cnt(iter3)
    );

    task automatic check(input string name, input int got, input int expv);
        checks++;
        if (got !== expv) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, expv);
        end
    endtask

    // Expected per-cycle outputs from go-accept to the ack edge, by plain subtractive Euclid.
    task automatic build_op(input int a, input int b, input int maxi, input bit corr,
                            input int hold, output int len, output int n);
        rec_t r;
        bit   fin_done;
        bit   stop;
        len = 0;
        n = 0;
        fin_done = 1'b0;
        stop = 1'b0;
        r = '{default: '0};
        r.ld = 1'b1; r.busy = 1'b1;
        exp_q.push_back(r); len++;
        for (int step = 0; step < 64 && !stop; step++) begin
            r = '{default: '0};
            r.busy = 1'b1;
            r.cnt = 4'(n);
            if (a == 0 || b == 0) begin
                stop = 1'b1;
            end else if (a == b) begin
                stop = 1'b1; fin_done = 1'b1;
            end else if (corr || n == maxi) begin
                stop = 1'b1;
            end else begin
                r.strt = 1'b1;
                r.sel = (a > b);
                if (a > b) a -= b; else b -= a;
                n++;
            end
            exp_q.push_back(r); len++;
        end
        for (int h = 0; h <= hold; h++) begin
            r = '{default: '0};
            r.cnt = 4'(n);
            if (fin_done) begin
                r.strt = 1'b1; r.out = 1'b1; r.done = 1'b1;
                r.chk_gcd = 1'b1; r.gcd = 4'(a);
            end else begin
                r.err = 1'b1;
            end
            exp_q.push_back(r); len++;
        end
    endtask

    task automatic run_op(input int a, input int b, input int hold, input bit corr,
                          input bit noisy, output int len, output int n);
        @(posedge clk); #1;
        da = 4'(a); db = 4'(b); corrupt = corr; go = 1'b1;
        @(posedge clk);
        build_op(a, b, 15, corr, hold, len, n);
        model_cnt = n;
        #1 go = 1'b0;
        for (int i = 0; i < len - 1; i++) begin
            @(posedge clk); #1;
            go = noisy ? 1'($urandom_range(0, 1)) : 1'b0;
        end
        ack = 1'b1;
        @(posedge clk); #1;
        ack = 1'b0; go = 1'b0; corrupt = 1'b0;
    endtask

    always @(negedge clk) begin : compare
        rec_t       r;
        logic [15:0] gv, ev;
        if (model_on) begin
            if (exp_q.size() > 0) begin
                r = exp_q.pop_front();
            end else begin
                r = '{default: '0};
                r.cnt = 4'(model_cnt);
            end
            gv = {ldA, ldB, sel, out, strt, busy, done, err, iter_cnt, (r.chk_gcd ? a_reg : 4'd0)};
            ev = {r.ld, r.ld, r.sel, r.out, r.strt, r.busy, r.done, r.err, r.cnt, (r.chk_gcd ? r.gcd : 4'd0)};
            check($sformatf("cycle@%0t ld,ld,sel,out,strt,busy,done,err,cnt,gcd", $time), int'(gv), int'(ev));
            if (out) last_gcd = int'(a_reg);
        end
    end

    initial begin
        int len, n, subs;
        bit saw_done;

        #2;
        check("reset outputs", int'({ldA, ldB, sel, out, strt, busy, done, err}), 0);
        check("reset iter_cnt", int'(iter_cnt), 0);
        @(negedge clk);
        rst = 1'b0;
        model_on = 1'b1;

        run_op(12, 8, 0, 1'b0, 1'b0, len, n);
        check("12_8 len", len, 5);
        check("12_8 n", n, 2);
        check("12_8 gcd", last_gcd, 4);
        check("12_8 iter_cnt", int'(iter_cnt), 2);

        run_op(15, 1, 0, 1'b0, 1'b1, len, n);
        check("15_1 n", n, 14);
        check("15_1 gcd", last_gcd, 1);
        check("15_1 iter_cnt", int'(iter_cnt), 14);

        run_op(0, 5, 0, 1'b0, 1'b1, len, n);
        check("0_5 len", len, 3);
        check("0_5 iter_cnt", int'(iter_cnt), 0);

        run_op(7, 7, 10, 1'b0, 1'b1, len, n);
        check("7_7 len", len, 13);
        check("7_7 gcd", last_gcd, 7);

        run_op(9, 6, 1, 1'b1, 1'b0, len, n);
        check("bad flags len", len, 4);

        for (int t = 0; t < 30; t++) begin
            run_op($urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 3),
                   1'b0, 1'b1, len, n);
        end

        // asynchronous reset in the middle of a calculation
        model_on = 1'b0;
        @(posedge clk); #1;
        da = 4'd9; db = 4'd6; go = 1'b1;
        @(posedge clk); #1 go = 1'b0;
        @(posedge clk); #1 go = 1'b1;
        @(posedge clk); #3;
        check("busy before rst", int'(busy), 1);
        rst = 1'b1;
        #1;
        check("async rst outputs", int'({ldA, ldB, sel, out, strt, busy, done, err, iter_cnt}), 0);
        go = 1'b0;
        @(posedge clk); #1;
        check("rst held outputs", int'({ldA, ldB, sel, out, strt, busy, done, err, iter_cnt}), 0);
        rst = 1'b0;
        model_cnt = 0;
        model_on = 1'b1;

        // timeout build: 15,1 with MAX_ITER=3
        @(posedge clk); #1 go3 = 1'b1;
        @(posedge clk); #1 go3 = 1'b0;
        subs = 0;
        saw_done = 1'b0;
        for (int i = 0; i < 40 && !err3; i++) begin
            @(negedge clk);
            if (strt3 && !out3) subs++;
            if (done3) saw_done = 1'b1;
        end
        check("timeout err", int'(err3), 1);
        check("timeout iter_cnt", int'(iter3), 3);
        check("timeout subs", subs, 3);
        check("timeout no done", int'(saw_done), 0);
        #1 ack3 = 1'b1;
        @(posedge clk); #1 ack3 = 1'b0;
        check("timeout ack clears err", int'(err3), 0);

        repeat (3) @(posedge clk);
        #1;
        check("queue drained", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
